// File: rtl/prbs_o150_burst_ctrl.sv
// rtl/prbs_o150_burst_ctrl.sv - O.150 PRBS word generator with seed load, burst counting and valid/ready stream.
// Optional single-bit error injection is built when PRBS_ERR_INJ_EN is defined.
module prbs_o150_burst_ctrl #(
  parameter int DATW = 64,
  parameter int STA0 = 9,
  parameter int STA1 = 5,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            istart,
  input  logic            istop,
  input  logic [LENW-1:0] ilen,
  input  logic            iseed_vld,
  input  logic [STA0-1:0] iseed,
  input  logic            iinj,
  input  logic            idat_rdy,
  output logic            odat_vld,
  output logic [DATW-1:0] odat,
  output logic            olast,
  output logic            obusy,
  output logic            odone,
  output logic            olockup
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [STA0-1:0] st_q, st_d;
  logic [DATW-1:0] odat_q, odat_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic            stop_pend_q, stop_pend_d;
  logic            start_pend_q, start_pend_d;
  logic [LENW-1:0] len_pend_q, len_pend_d;
  logic            done_q, done_d;
  logic            lock_q, lock_d;

  logic [STA0-1:0] st_nxt;
  logic [DATW-1:0] dat_nxt;
  logic            inj_now;
  logic            load;
  logic            last;
  logic [LENW-1:0] start_len;
  logic            start_go;

  // Advances the Fibonacci LFSR DATW times; the feedback bit is also the output bit, MSB first.
  function automatic logic [STA0+DATW-1:0] prbs_step(input logic [STA0-1:0] s_in);
    logic [STA0-1:0] s;
    logic [DATW-1:0] w;
    logic            fb;
    s = s_in;
    w = '0;
    for (int i = 0; i < DATW; i++) begin
      fb = s[STA0-1] ^ s[STA1-1];
      s  = {s[STA0-2:0], fb};
      w  = {w[DATW-2:0], fb};
    end
    return {s, w};
  endfunction

  always_comb begin
    {st_nxt, dat_nxt} = prbs_step(st_q);
  end

`ifdef PRBS_ERR_INJ_EN
  logic inj_pend_q, inj_pend_d;

  // A request arriving in the same cycle as a load is applied to that load.
  assign inj_now    = inj_pend_q | iinj;
  assign inj_pend_d = load ? 1'b0 : inj_now;

  always_ff @(posedge clk) begin
    if (rst) inj_pend_q <= 1'b0;
    else     inj_pend_q <= inj_pend_d;
  end
`else
  logic unused_iinj;
  assign unused_iinj = iinj;
  assign inj_now     = 1'b0;
`endif

  assign last = (cnt_q == LENW'(1)) || stop_pend_q;

  always_comb begin
    state_d      = state_q;
    st_d         = st_q;
    odat_d       = odat_q;
    cnt_d        = cnt_q;
    stop_pend_d  = stop_pend_q;
    start_pend_d = start_pend_q;
    len_pend_d   = len_pend_q;
    done_d       = 1'b0;
    lock_d       = 1'b0;
    load         = 1'b0;
    start_go     = 1'b0;
    start_len    = ilen;

    case (state_q)
      S_IDLE: begin
        if (start_pend_q) begin
          start_go     = 1'b1;
          start_len    = len_pend_q;
          start_pend_d = 1'b0;
        end else if (iseed_vld) begin
          // Seed takes this cycle; a simultaneous start is deferred so it sees the new seed.
          st_d   = (iseed == '0) ? '1 : iseed;
          lock_d = (iseed == '0);
          if (istart) begin
            start_pend_d = 1'b1;
            len_pend_d   = ilen;
          end
        end else if (istart) begin
          start_go = 1'b1;
        end
        if (start_go) begin
          load        = 1'b1;
          cnt_d       = start_len;
          stop_pend_d = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (idat_rdy && last) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end else begin
          if (idat_rdy) begin
            load = 1'b1;
            if (cnt_q != '0) cnt_d = cnt_q - LENW'(1);
          end
          if (istop) stop_pend_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      st_d   = st_nxt;
      odat_d = dat_nxt ^ {inj_now, {(DATW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      st_q         <= '1;
      odat_q       <= '0;
      cnt_q        <= '0;
      stop_pend_q  <= 1'b0;
      start_pend_q <= 1'b0;
      len_pend_q   <= '0;
      done_q       <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      st_q         <= st_d;
      odat_q       <= odat_d;
      cnt_q        <= cnt_d;
      stop_pend_q  <= stop_pend_d;
      start_pend_q <= start_pend_d;
      len_pend_q   <= len_pend_d;
      done_q       <= done_d;
      lock_q       <= lock_d;
    end
  end

  assign odat_vld = (state_q == S_RUN);
  assign odat     = odat_q;
  assign olast    = odat_vld & last;
  assign obusy    = (state_q != S_IDLE);
  assign odone    = done_q;
  assign olockup  = lock_q;

endmodule
